ifetch_queue: RTL

Instruction fetch unit that sits directly upstream of the instruction port of the magic dual-port memory. It owns the fetch PC, issues one-word reads back-to-back, and buffers returned instructions with their PCs in a small FIFO for the decode stage. Control-flow redirects flush the FIFO and discard any in-flight response.

---
 rtl/ifetch_queue.sv | 99 +++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Fetch PC owner and small instruction FIFO feeding decode; redirects flush queue and in-flight read.
// Optional macro IFETCH_BYPASS_EN: a response arriving at an empty queue is shown to decode the same cycle.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  output logic                       imem_read,
  input  logic [31:0]                imem_rdata,
  input  logic                       imem_resp,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic          drop;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [CW:0]   occ;
  logic          accept;
  logic          enq;
  logic          pop;

  // Reserve a slot for the outstanding read so a response can never overflow the queue
  assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_read = rst & ~redirect_valid & (occ < DEPTH_W);
  assign imem_addr = pc;
  assign accept    = imem_resp & inflight & ~drop & ~redirect_valid;
  assign pop       = (count != '0) & inst_ready & ~redirect_valid;
  assign queue_count = count;

  always_comb begin
    enq        = accept;
    inst_valid = (count != '0);
    inst_data  = mem_data[head];
    inst_pc    = mem_pc[head];
`ifdef IFETCH_BYPASS_EN
    if (accept && count == '0) begin
      inst_valid = 1'b1;
      inst_data  = imem_rdata;
      inst_pc    = req_pc;
      enq        = ~inst_ready;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      drop     <= redirect_valid & inflight;
      inflight <= imem_read;
      if (redirect_valid) begin
        pc    <= redirect_pc & 32'hFFFF_FFFC;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (imem_read) begin
          pc     <= pc + 32'd4;
          req_pc <= pc;
        end
        if (enq) begin
          mem_pc[tail]   <= req_pc;
          mem_data[tail] <= imem_rdata;
          tail           <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        count <= count + CW'(enq) - CW'(pop);
      end
    end
  end

endmodule
